// File: rtl/data_memory_responder_if.sv
// Data-memory port bundle between the core (master) and the responder (slave).
// Carries the read/write strobes, byte address, write data and registered read data.
interface data_memory_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;

  modport master (
    output memRead,
    output memWrite,
    output memAddr,
    output memDataIn,
    input  memDataOut
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  memAddr,
    input  memDataIn,
    output memDataOut
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory target: word RAM, 1-cycle reads, fault pulse/count, optional MMIO
// (DMEM_MMIO_EN: LED reg, cycle counter). Ports: CLK, RES, bus, fault, faultCount, ledOut.
module data_memory_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic                           CLK,
  input  logic                           RES,
  data_memory_responder_if.slave         bus,
  output logic                           fault,
  output logic [7:0]                     faultCount,
  output logic [31:0]                    ledOut
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LAST_ADDR =
    BASE_ADDR + 32'(DEPTH * 4) - 32'd1;

  logic [31:0] mem [DEPTH];

  logic [31:0]   offs;
  logic [AW-1:0] idx;
  logic          inRam;
  logic          misAl;
  logic          req;
  logic          mmioHit;
  logic          reject;
  logic          wrOk;
  logic [31:0]   mmioRd;
  logic [31:0]   rdData;

  assign offs  = bus.memAddr - BASE_ADDR;
  assign idx   = AW'(offs >> 2);
  assign inRam = (bus.memAddr >= BASE_ADDR) &&
                 (bus.memAddr <= LAST_ADDR);
  assign misAl = |bus.memAddr[1:0];
  assign req   = bus.memRead | bus.memWrite;

  // One reject decision covers both strobes, so a
  // rejected read+write counts as a single fault.
  assign reject = req & (misAl | ~(inRam | mmioHit));
  assign wrOk   = bus.memWrite & ~reject;

`ifdef DMEM_MMIO_EN
  logic [31:0] ledReg;
  logic [31:0] cycCnt;
  logic        isLed;
  logic        isCnt;

  assign isLed   = bus.memAddr == MMIO_BASE;
  assign isCnt   = bus.memAddr == MMIO_BASE + 32'd4;
  assign mmioHit = isLed | isCnt;
  assign mmioRd  = isLed ? ledReg : cycCnt;

  // Counter reads see the pre-increment value; writes
  // to the counter slot are accepted but dropped.
  always_ff @(posedge CLK) begin
    if (RES) begin
      ledReg <= '0;
      cycCnt <= '0;
    end else begin
      cycCnt <= cycCnt + 32'd1;
      if (wrOk && !inRam && isLed)
        ledReg <= bus.memDataIn;
    end
  end

  assign ledOut = ledReg;
`else
  assign mmioHit = 1'b0;
  assign mmioRd  = '0;
  assign ledOut  = '0;
`endif

  assign rdData = inRam ? mem[idx] : mmioRd;

  // RAM is never cleared; writes in a reset cycle are
  // dropped. Nonblocking update gives read-first.
  always_ff @(posedge CLK) begin
    if (!RES && wrOk && inRam)
      mem[idx] <= bus.memDataIn;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      bus.memDataOut <= '0;
      fault          <= 1'b0;
      faultCount     <= '0;
    end else begin
      fault <= reject;
      if (reject && faultCount != 8'hFF)
        faultCount <= faultCount + 8'd1;
      if (bus.memRead)
        bus.memDataOut <= reject ? 32'd0 : rdData;
    end
  end

endmodule
